// File: rtl/udp_tx_sched.sv
// Round-robin UDP transmit scheduler: arbitrates NREQ frame requesters, emits a UDP header
// and counts 8-byte payload beats until the frame completes.
module udp_tx_sched #(
  parameter int NREQ    = 4,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic              clk156,
  input  logic              sys_rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*16-1:0] req_frame_len,
  input  logic [NREQ*16-1:0] req_sport,
  input  logic [NREQ*16-1:0] req_dport,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rej,
  output logic              hdr_valid,
  input  logic              hdr_ready,
  output logic [15:0]       hdr_source,
  output logic [15:0]       hdr_dest,
  output logic [15:0]       hdr_len,
  output logic [15:0]       hdr_check,
  input  logic              beat,
  output logic              body_last,
  output logic              busy,
  output logic [31:0]       frame_cnt,
  output logic [1:0]        dbg_state
);

  // Header handshake: a header transfers on a cycle where hdr_valid && hdr_ready;
  // hdr_valid never drops and the fields never change until that transfer happens.
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, BODY = 2'd2} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   rr_ptr, sel_idx, own_idx;
  logic            sel_found, in_range, arb_ok;
  logic [15:0]     sel_len, len_q, beats_left;
  logic [31:0]     cnt_q;
  logic [NREQ-1:0] sel_onehot;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (int'(p) == NREQ - 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!sel_found && req[(int'(rr_ptr) + k) % NREQ]) begin
        sel_found = 1'b1;
        sel_idx   = PW'((int'(rr_ptr) + k) % NREQ);
      end
    end
    sel_len    = req_frame_len[16*sel_idx +: 16];
    sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
    in_range   = (sel_len >= 16'(MIN_LEN)) && (sel_len <= 16'(MAX_LEN));
    // A reject pulse cycle skips arbitration so a still-held rejected request is not hit twice.
    arb_ok     = (state == IDLE) && sel_found && (rej == '0);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (arb_ok && in_range) state_n = HDR;
      HDR:     if (hdr_valid && hdr_ready) state_n = BODY;
      BODY:    if (beat && body_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign body_last = (state == BODY) && (beats_left == 16'd1);
  assign busy      = (state != IDLE);
  assign frame_cnt = cnt_q;
  assign dbg_state = state;

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      state      <= IDLE;
      gnt        <= '0;
      rej        <= '0;
      hdr_valid  <= 1'b0;
      hdr_source <= '0;
      hdr_dest   <= '0;
      hdr_len    <= '0;
      hdr_check  <= '0;
      beats_left <= '0;
      rr_ptr     <= '0;
      own_idx    <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state <= state_n;
      rej   <= '0;
      case (state)
        IDLE: begin
          if (arb_ok) begin
            if (in_range) begin
              gnt        <= sel_onehot;
              hdr_valid  <= 1'b1;
              hdr_source <= req_sport[16*sel_idx +: 16];
              hdr_dest   <= req_dport[16*sel_idx +: 16];
              hdr_len    <= sel_len - 16'd38;
              hdr_check  <= 16'd0;
              own_idx    <= sel_idx;
              len_q      <= sel_len;
            end else begin
              rej    <= sel_onehot;
              rr_ptr <= ptr_inc(sel_idx);
            end
          end
        end
        HDR: begin
          if (hdr_ready) begin
            hdr_valid  <= 1'b0;
            // ceil((len - 46) / 8) == (len - 39) >> 3
            beats_left <= (len_q - 16'd39) >> 3;
          end
        end
        BODY: begin
          if (beat) begin
            beats_left <= beats_left - 16'd1;
            if (body_last) begin
              gnt    <= '0;
              rr_ptr <= ptr_inc(own_idx);
              cnt_q  <= cnt_q + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
